// File: rtl/ppc_types.sv
// Shared processor types: result-bus entry layout and default datapath widths.
package ppc_types;

  localparam int unsigned PPC_OPERAND_WIDTH = 32;
  localparam int unsigned PPC_RS_ID_WIDTH   = 5;

  typedef struct packed {
    logic [PPC_RS_ID_WIDTH-1:0]   rs_id;
    logic [PPC_OPERAND_WIDTH-1:0] value;
  } result_entry_t;

endpackage

// File: rtl/result_fifo.sv
// Single-clock FIFO buffering one execution unit's results ahead of the bus.
// Push is ignored when full and pop is ignored when empty.
module result_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/result_bus_arbiter.sv
// Result broadcast bus: per-unit FIFOs, one grant per cycle, registered
// broadcast replicated on every operand lane.
// Define RESULT_BUS_RR_EN for round-robin arbitration; otherwise fixed
// priority (lowest unit index wins).
module result_bus_arbiter
  import ppc_types::*;
#(
  parameter int unsigned UNITS         = 4,
  parameter int unsigned OPERANDS      = 2,
  parameter int unsigned OPERAND_WIDTH = PPC_OPERAND_WIDTH,
  parameter int unsigned RS_ID_WIDTH   = PPC_RS_ID_WIDTH,
  parameter int unsigned BUF_DEPTH     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     unit_valid      [0:UNITS-1],
  output logic                     unit_ready      [0:UNITS-1],
  input  logic [RS_ID_WIDTH-1:0]   unit_rs_id      [0:UNITS-1],
  input  logic [OPERAND_WIDTH-1:0] unit_value      [0:UNITS-1],
  output logic                     operand_valid   [0:OPERANDS-1],
  output logic [RS_ID_WIDTH-1:0]   update_op_rs_id [0:OPERANDS-1],
  output logic [OPERAND_WIDTH-1:0] update_op_value [0:OPERANDS-1],
  output logic [$clog2(UNITS)-1:0] grant_unit
);

  localparam int unsigned UW = $clog2(UNITS);
  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

  typedef struct packed {
    logic [RS_ID_WIDTH-1:0]   rs_id;
    logic [OPERAND_WIDTH-1:0] value;
  } entry_t;

  entry_t          push_data [UNITS];
  entry_t          head      [UNITS];
  logic            full      [UNITS];
  logic            empty     [UNITS];
  logic            pop       [UNITS];
  logic [CW-1:0]   count     [UNITS];

  logic            grant_valid;
  logic [UW-1:0]   grant_idx;

  logic            out_valid;
  entry_t          out_entry;

  for (genvar u = 0; u < UNITS; u++) begin : g_unit
    assign push_data[u] = {unit_rs_id[u], unit_value[u]};
    assign unit_ready[u] = ~full[u];
    assign pop[u]        = grant_valid && (grant_idx == UW'(u));

    result_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (BUF_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (unit_valid[u]),
      .pop   (pop[u]),
      .din   (push_data[u]),
      .dout  (head[u]),
      .count (count[u]),
      .full  (full[u]),
      .empty (empty[u])
    );
  end

`ifdef RESULT_BUS_RR_EN
  logic [UW-1:0] rr;
  logic [UW-1:0] cand;

  // Round-robin pick: first non-empty FIFO at or after rr, wrapping.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 0; i < UNITS; i++) begin
      cand = UW'((32'(rr) + i) % UNITS);
      if (!grant_valid && !empty[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Priority pointer moves just past the most recent winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr <= '0;
    end else if (grant_valid) begin
      rr <= (grant_idx == UW'(UNITS - 1)) ? '0 : grant_idx + UW'(1);
    end
  end
`else
  // Fixed priority: scan downward so the lowest non-empty index is the last write.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int unsigned i = UNITS; i > 0; i--) begin
      if (!empty[i-1]) begin
        grant_valid = 1'b1;
        grant_idx   = UW'(i - 1);
      end
    end
  end
`endif

  // Broadcast register: loads the winner's head entry; tag/value/grant hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_entry  <= '0;
      grant_unit <= '0;
    end else begin
      out_valid <= grant_valid;
      if (grant_valid) begin
        out_entry  <= head[grant_idx];
        grant_unit <= grant_idx;
      end
    end
  end

  for (genvar l = 0; l < OPERANDS; l++) begin : g_lane
    assign operand_valid[l]   = out_valid;
    assign update_op_rs_id[l] = out_entry.rs_id;
    assign update_op_value[l] = out_entry.value;
  end

endmodule
